// File: rtl/kernel_sysid_pkg.sv
// Shared constants for the boot-time system-ID checker: FSM encoding, sysid
// register map, default build-time expectations and watchdog counter width.
package kernel_sysid_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StRdId   = 2'd1;
    localparam state_t StRdTs   = 2'd2;
    localparam state_t StFinish = 2'd3;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0FFF_FFFF;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5B7E_C4CA;

    localparam int unsigned WDT_WIDTH = 16;

endpackage

// File: rtl/kernel_sysid_checker_if.sv
// Avalon-MM read-only master bundle between the checker and the sysid slave.
interface kernel_sysid_checker_if;

    logic        m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;

    modport master (
        output m_address,
        output m_read,
        input  m_readdata,
        input  m_waitrequest
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_readdata,
        output m_waitrequest
    );

endinterface

// File: rtl/kernel_sysid_wdt.sv
// Per-read stall watchdog: clear on entry to a read, count stalled cycles,
// saturate at the limit and flag it.
module kernel_sysid_wdt
    import kernel_sysid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [WDT_WIDTH-1:0] Limit = WDT_WIDTH'(TIMEOUT_CYCLES);

    logic [WDT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != Limit)) begin
            count_d = count_q + WDT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == Limit);

endmodule

// File: rtl/kernel_sysid_checker.sv
// Boot-time checker: reads sysid ID then timestamp over Avalon-MM, compares
// both against build-time values and reports match/timeout status.
module kernel_sysid_checker
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    kernel_sysid_checker_if.master m,
    output logic                   busy,
    output logic                   done,
    output logic                   id_ok,
    output logic                   ts_ok,
    output logic                   timeout,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value
);

    state_t      state_q, state_d;
    logic        auto_q, auto_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
    logic        wdt_expired;

    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        read_d     = read_q;
        addr_d     = addr_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        case (state_q)
            StIdle: begin
                if (start || auto_q) begin
                    state_d    = StRdId;
                    auto_d     = 1'b0;
                    read_d     = 1'b1;
                    addr_d     = SYSID_ADDR_ID;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    id_value_d = '0;
                    ts_value_d = '0;
                end
            end
            StRdId: begin
                if (!m.m_waitrequest) begin
                    id_value_d = m.m_readdata;
                    id_ok_d    = (m.m_readdata == EXPECTED_ID);
                    addr_d     = SYSID_ADDR_TS;
                    state_d    = StRdTs;
                end else if (wdt_expired) begin
                    // Abandon the whole check; the timestamp is never read.
                    read_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StFinish;
                end
            end
            StRdTs: begin
                if (!m.m_waitrequest) begin
                    ts_value_d = m.m_readdata;
                    ts_ok_d    = (m.m_readdata == EXPECTED_TS);
                    read_d     = 1'b0;
                    state_d    = StFinish;
                end else if (wdt_expired) begin
                    read_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            auto_q     <= AUTO_START;
            read_q     <= 1'b0;
            addr_q     <= SYSID_ADDR_ID;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    // Any state change restarts the stall budget, so each read gets a full one.
    kernel_sysid_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .inc     (read_q && m.m_waitrequest),
        .expired (wdt_expired)
    );

    assign m.m_read    = read_q;
    assign m.m_address = addr_q;
    assign busy        = (state_q == StRdId) || (state_q == StRdTs);
    assign done        = (state_q == StFinish);
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Directed bench for kernel_sysid_checker: one default DUT plus a short-timeout
// DUT, each driven by a small sysid slave model with programmable stalls.
module tb_kernel_sysid_checker;

    logic clock = 1'b0;
    logic reset_n;
    logic start, start_to;

    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    logic        busy_to, done_to, id_ok_to, ts_ok_to, timeout_to;
    logic [31:0] id_value_to, ts_value_to;

    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall_len;
    logic        stuck_ts_to;
    int          sc, sc_to;

    int n_cmp = 0;
    int n_bad = 0;

    kernel_sysid_checker_if bus ();
    kernel_sysid_checker_if bus_to ();

    always #5 clock = ~clock;

    kernel_sysid_checker dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .m        (bus),
        .busy     (busy),
        .done     (done),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout),
        .id_value (id_value),
        .ts_value (ts_value)
    );

    kernel_sysid_checker #(
        .TIMEOUT_CYCLES (8)
    ) dut_to (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start_to),
        .m        (bus_to),
        .busy     (busy_to),
        .done     (done_to),
        .id_ok    (id_ok_to),
        .ts_ok    (ts_ok_to),
        .timeout  (timeout_to),
        .id_value (id_value_to),
        .ts_value (ts_value_to)
    );

    // Slave models: stall each read for stall_len cycles, then accept.
    assign bus.m_readdata      = bus.m_address ? ts_word : id_word;
    assign bus.m_waitrequest   = bus.m_read && (sc < stall_len);
    assign bus_to.m_readdata   = bus_to.m_address ? ts_word : id_word;
    assign bus_to.m_waitrequest = bus_to.m_read && (stuck_ts_to && bus_to.m_address);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sc    <= 0;
            sc_to <= 0;
        end else begin
            sc    <= (bus.m_read && bus.m_waitrequest) ? sc + 1 : 0;
            sc_to <= (bus_to.m_read && bus_to.m_waitrequest) ? sc_to + 1 : 0;
        end
    end

    // Monitors sampled on the falling edge.
    logic mon_en = 1'b0;
    logic p_rw = 1'b0;
    logic p_addr = 1'b0;
    int   stall_seen = 0;
    int   stall_viol = 0;
    int   done_cnt = 0;
    int   done_to_cnt = 0;

    always @(negedge clock) begin
        if (done)    done_cnt <= done_cnt + 1;
        if (done_to) done_to_cnt <= done_to_cnt + 1;
        if (mon_en) begin
            if (p_rw) begin
                stall_seen <= stall_seen + 1;
                if (!(bus.m_read && bus.m_address == p_addr)) stall_viol <= stall_viol + 1;
            end
            p_rw   <= bus.m_read && bus.m_waitrequest;
            p_addr <= bus.m_address;
        end else begin
            p_rw <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle from the current falling edge, then count
    // falling edges until done (1 = cycle right after start was sampled).
    task automatic run_check(input int max, output int lat);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < max) begin
            @(negedge clock);
            lat++;
        end
    endtask

    int lat;
    int c0;
    logic read_at10;

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        start_to    = 1'b0;
        id_word     = 32'h0FFF_FFFF;
        ts_word     = 32'h5B7E_C4CA;
        stall_len   = 0;
        stuck_ts_to = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_read", bus.m_read, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", {id_ok, ts_ok, timeout}, 0);
        check("rst_id_value", id_value, 0);

        // Auto start, zero-wait
        reset_n = 1'b1;
        @(negedge clock);
        check("auto_c1_rd_addr", {bus.m_read, bus.m_address, busy}, 3'b101);
        @(negedge clock);
        check("auto_c2_rd_addr", {bus.m_read, bus.m_address, busy}, 3'b111);
        @(negedge clock);
        check("auto_c3_done", {done, busy, bus.m_read}, 3'b100);
        check("auto_flags", {id_ok, ts_ok, timeout}, 3'b110);
        check("auto_id_value", id_value, 32'h0FFF_FFFF);
        check("auto_ts_value", ts_value, 32'h5B7E_C4CA);
        @(negedge clock);
        check("auto_done_once", done, 0);
        check("auto_hold", {id_ok, ts_ok}, 2'b11);

        // ID mismatch still reads the timestamp
        id_word = 32'h0FFF_FFFE;
        run_check(40, lat);
        check("idbad_latency", lat, 3);
        check("idbad_flags", {id_ok, ts_ok, timeout}, 3'b010);
        check("idbad_id_value", id_value, 32'h0FFF_FFFE);
        @(negedge clock);
        check("idbad_done_once", done, 0);

        // Five stall cycles on each read
        id_word   = 32'h0FFF_FFFF;
        stall_len = 5;
        mon_en    = 1'b1;
        run_check(60, lat);
        check("stall_latency", lat, 13);
        check("stall_flags", {id_ok, ts_ok, timeout}, 3'b110);
        @(negedge clock);
        mon_en = 1'b0;
        check("stall_cycles_seen", stall_seen, 10);
        check("stall_stable", stall_viol, 0);
        stall_len = 0;

        // Timeout on the timestamp read (limit 8)
        reset_n     = 1'b0;
        stuck_ts_to = 1'b1;
        repeat (2) @(negedge clock);
        c0 = done_to_cnt;
        reset_n = 1'b1;
        read_at10 = 1'b0;
        @(negedge clock);
        lat = 1;
        while (!done_to && lat < 40) begin
            if (lat == 10) read_at10 = bus_to.m_read;
            @(negedge clock);
            lat++;
        end
        check("to_latency", lat, 11);
        check("to_read_before_expiry", read_at10, 1);
        check("to_read_dropped", bus_to.m_read, 0);
        check("to_flags", {id_ok_to, ts_ok_to, timeout_to}, 3'b101);
        check("to_ts_value", ts_value_to, 0);
        repeat (5) @(negedge clock);
        check("to_done_count", done_to_cnt - c0, 1);
        check("to_idle", {busy_to, bus_to.m_read}, 0);
        stuck_ts_to = 1'b0;

        // Start held high while busy and through the done cycle
        id_word = 32'h1234_5678;
        c0 = done_cnt;
        start = 1'b1;
        @(negedge clock);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("hold_latency", lat, 3);
        @(negedge clock);
        start = 1'b0;
        check("hold_no_restart", busy, 0);
        repeat (5) @(negedge clock);
        check("hold_done_count", done_cnt - c0, 1);
        check("hold_id_value", id_value, 32'h1234_5678);

        // Start one cycle after done clears status and reruns
        run_check(40, lat);
        check("rerun_a_latency", lat, 3);
        @(negedge clock);
        id_word   = 32'h0FFF_FFFF;
        stall_len = 2;
        run_check(40, lat);
        check("rerun_b_latency", lat, 7);
        check("rerun_b_flags", {id_ok, ts_ok, timeout}, 3'b110);
        check("rerun_b_id_value", id_value, 32'h0FFF_FFFF);

        // Status is cleared on the start edge
        @(negedge clock);
        stall_len = 20;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("clr_status", {id_ok, ts_ok, timeout}, 0);
        check("clr_id_value", id_value, 0);
        @(negedge clock);
        check("midrst_pre_read", {bus.m_read, busy}, 2'b11);

        // Reset during the ID stall
        reset_n = 1'b0;
        #1;
        check("midrst_read", bus.m_read, 0);
        check("midrst_busy", busy, 0);
        stall_len = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check("midrst_auto_latency", lat, 3);
        check("midrst_auto_flags", {id_ok, ts_ok, timeout}, 3'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
